// File: rtl/vram_slot_arbiter_pkg.sv
// sys1 VRAM arbiter shared package
// Widths, slot kinds, FSM states and the slot-kind rule
package sys1_vram_pkg;

  localparam int AW = 14;
  localparam int DW = 8;

  typedef enum logic {
    SLOT_VID,
    SLOT_CPU
  } slot_e;

  typedef enum logic [2:0] {
    IDLE,
    VADDR,
    VDATA,
    CADDR,
    CDATA
  } state_e;

  // Video owns even pixels of the active area, CPU owns the rest
  function automatic slot_e slot_kind(
    input logic hpos0,
    input logic hblk,
    input logic vblk
  );
    return (!hblk && !vblk && !hpos0) ? SLOT_VID : SLOT_CPU;
  endfunction

endpackage

// File: rtl/vram_slot_arbiter_if.sv
// VRAM arbiter bus bundle
// Raster, video fetch, CPU handshake and RAM port signals
interface vram_slot_arbiter_if;
  import sys1_vram_pkg::*;

  logic          PCLK_EN;
  logic [8:0]    HPOS;
  logic          HBLK;
  logic          VBLK;
  logic [AW-1:0] VID_AD;
  logic [DW-1:0] VID_DT;
  logic          VID_DV;
  logic          CPU_RQ;
  logic          CPU_WE;
  logic [AW-1:0] CPU_AD;
  logic [DW-1:0] CPU_DI;
  logic [DW-1:0] CPU_DT;
  logic          CPU_ACK;
  logic          CPU_WAIT;
  logic [AW-1:0] RAM_AD;
  logic          RAM_WE;
  logic [DW-1:0] RAM_DI;
  logic [DW-1:0] RAM_DO;

  modport slave (
    input  PCLK_EN, HPOS, HBLK, VBLK,
    input  VID_AD,
    input  CPU_RQ, CPU_WE, CPU_AD, CPU_DI,
    input  RAM_DO,
    output VID_DT, VID_DV,
    output CPU_DT, CPU_ACK, CPU_WAIT,
    output RAM_AD, RAM_WE, RAM_DI
  );

  modport master (
    output PCLK_EN, HPOS, HBLK, VBLK,
    output VID_AD,
    output CPU_RQ, CPU_WE, CPU_AD, CPU_DI,
    output RAM_DO,
    input  VID_DT, VID_DV,
    input  CPU_DT, CPU_ACK, CPU_WAIT,
    input  RAM_AD, RAM_WE, RAM_DI
  );

endinterface

// File: rtl/vram_wbuf.sv
// Single-entry posted CPU write buffer
// Only built when VRAM_CPU_WBUF_EN is defined
`ifdef VRAM_CPU_WBUF_EN
module vram_wbuf
  import sys1_vram_pkg::*;
(
  input  logic          CLK,
  input  logic          RESET,
  input  logic          ld,
  input  logic [AW-1:0] ld_ad,
  input  logic [DW-1:0] ld_di,
  input  logic          drain,
  output logic          full,
  output logic [AW-1:0] ad,
  output logic [DW-1:0] di
);

  // Load wins; load and drain never coincide since load needs empty
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      full <= 1'b0;
      ad   <= '0;
      di   <= '0;
    end else if (ld) begin
      full <= 1'b1;
      ad   <= ld_ad;
      di   <= ld_di;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

endmodule
`endif

// File: rtl/vram_slot_arbiter.sv
// Time-slot VRAM arbiter: video fetch vs CPU
// Optional posted write buffer: VRAM_CPU_WBUF_EN
module vram_slot_arbiter
  import sys1_vram_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET,
  vram_slot_arbiter_if.slave bus
);

  state_e        state;
  slot_e         kind;
  logic          done;
  logic          c_rd;
  logic          c_ack;

  logic          post;
  logic          cpu_go;
  logic [AW-1:0] c_ad;
  logic          c_we;
  logic [DW-1:0] c_di;
  logic          c_rd_n;
  logic          c_ack_n;

  logic [AW-1:0] ram_ad;
  logic          ram_we;
  logic [DW-1:0] ram_di;
  logic [DW-1:0] vid_dt;
  logic          vid_dv;
  logic [DW-1:0] cpu_dt;
  logic          cpu_ack;

  assign kind = slot_kind(bus.HPOS[0], bus.HBLK, bus.VBLK);

`ifdef VRAM_CPU_WBUF_EN
  logic          wb_full;
  logic          wb_drain;
  logic [AW-1:0] wb_ad;
  logic [DW-1:0] wb_di;

  assign post = bus.CPU_RQ & bus.CPU_WE
              & ~done & ~wb_full;
  assign cpu_go = wb_full
                | (bus.CPU_RQ & ~bus.CPU_WE & ~done);
  assign c_ad    = wb_full ? wb_ad : bus.CPU_AD;
  assign c_we    = wb_full;
  assign c_di    = wb_full ? wb_di : bus.CPU_DI;
  assign c_rd_n  = ~wb_full;
  assign c_ack_n = ~wb_full;
  assign wb_drain = (state == IDLE) & bus.PCLK_EN
                  & (kind == SLOT_CPU) & wb_full;

  vram_wbuf u_wbuf (
    .CLK   (CLK),
    .RESET (RESET),
    .ld    (post),
    .ld_ad (bus.CPU_AD),
    .ld_di (bus.CPU_DI),
    .drain (wb_drain),
    .full  (wb_full),
    .ad    (wb_ad),
    .di    (wb_di)
  );
`else
  assign post    = 1'b0;
  assign cpu_go  = bus.CPU_RQ & ~done;
  assign c_ad    = bus.CPU_AD;
  assign c_we    = bus.CPU_WE;
  assign c_di    = bus.CPU_DI;
  assign c_rd_n  = ~bus.CPU_WE;
  assign c_ack_n = 1'b1;
`endif

  // Slot FSM with registered RAM port and handshake outputs
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= IDLE;
      done    <= 1'b0;
      c_rd    <= 1'b0;
      c_ack   <= 1'b0;
      ram_ad  <= '0;
      ram_we  <= 1'b0;
      ram_di  <= '0;
      vid_dt  <= '0;
      vid_dv  <= 1'b0;
      cpu_dt  <= '0;
      cpu_ack <= 1'b0;
    end else begin
      vid_dv  <= 1'b0;
      cpu_ack <= post;
      if (!bus.CPU_RQ) done <= 1'b0;
      if (post) done <= 1'b1;
      unique case (state)
        IDLE: begin
          if (bus.PCLK_EN) begin
            if (kind == SLOT_VID) begin
              state  <= VADDR;
              ram_ad <= bus.VID_AD;
              ram_we <= 1'b0;
              ram_di <= bus.CPU_DI;
            end else if (cpu_go) begin
              state  <= CADDR;
              ram_ad <= c_ad;
              ram_we <= c_we;
              ram_di <= c_di;
              c_rd   <= c_rd_n;
              c_ack  <= c_ack_n;
            end
          end
        end
        VADDR: begin
          ram_we <= 1'b0;
          state  <= VDATA;
        end
        VDATA: begin
          vid_dt <= bus.RAM_DO;
          vid_dv <= 1'b1;
          state  <= IDLE;
        end
        CADDR: begin
          ram_we <= 1'b0;
          state  <= CDATA;
        end
        CDATA: begin
          if (c_rd) cpu_dt <= bus.RAM_DO;
          if (c_ack) begin
            cpu_ack <= 1'b1;
            done    <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.RAM_AD   = ram_ad;
  assign bus.RAM_WE   = ram_we;
  assign bus.RAM_DI   = ram_di;
  assign bus.VID_DT   = vid_dt;
  assign bus.VID_DV   = vid_dv;
  assign bus.CPU_DT   = cpu_dt;
  assign bus.CPU_ACK  = cpu_ack;
  assign bus.CPU_WAIT = bus.CPU_RQ & ~cpu_ack
                      & ~done & ~RESET;

endmodule

// File: tb/tb_vram_slot_arbiter.sv
// Self-checking bench for vram_slot_arbiter
// Vector table, directed sequences, random slots vs model
module tb_vram_slot_arbiter;

  localparam int K_NONE = 0;
  localparam int K_VID  = 1;
  localparam int K_CPU  = 2;

  typedef struct {
    logic [8:0]  hpos;
    logic        hb;
    logic        vb;
    logic [13:0] vad;
    logic        rq;
    logic        we;
    logic [13:0] cad;
    logic [7:0]  di;
    int          kind;
    logic [7:0]  dt;
  } vec_t;

  logic CLK = 1'b0;
  logic RESET;

  vram_slot_arbiter_if bus ();

  vram_slot_arbiter dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  always #5 CLK = ~CLK;

  logic        bk_init = 1'b0;
  logic        bk_we   = 1'b0;
  logic [13:0] bk_ad   = '0;
  logic [7:0]  bk_di   = '0;
  logic [7:0]  mem     [0:16383];
  logic [7:0]  ref_mem [0:16383];

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [13:0] last_ad = '0;
  logic        m_done  = 1'b0;
  int          nwe;
  int          nack;
  vec_t        tbl [12];
  vec_t        v;
  logic [8:0]  r_hp;
  logic        r_hb;
  logic        r_vb;
  logic [13:0] r_vad;
  logic [13:0] r_ead;
  logic [7:0]  r_dt;
  int          r_kind;

  function automatic logic [7:0] finit(input int a);
    return 8'(a) ^ 8'hA5;
  endfunction

  // Synchronous RAM, read-first, with a bench backdoor
  always @(posedge CLK) begin
    if (bk_init) begin
      for (int i = 0; i < 16384; i++) mem[i] <= finit(i);
    end else if (bk_we) begin
      mem[bk_ad] <= bk_di;
    end else if (bus.RAM_WE) begin
      mem[bus.RAM_AD] <= bus.RAM_DI;
    end
    bus.RAM_DO <= mem[bus.RAM_AD];
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic poke(input logic [13:0] a,
                      input logic [7:0] d);
    bk_we = 1'b1;
    bk_ad = a;
    bk_di = d;
    tick();
    bk_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic release_rq();
    bus.CPU_RQ = 1'b0;
    m_done = 1'b0;
    tick();
  endtask

  // One slot: strobe, then check E0, E1, E2, E3
  task automatic slot(input string tg,
                      input logic [8:0] hp,
                      input logic hb,
                      input logic vb,
                      input logic [13:0] vad,
                      input logic ev,
                      input logic ec,
                      input logic ew,
                      input logic [13:0] ead,
                      input logic [7:0] edt);
    bus.HPOS    = hp;
    bus.HBLK    = hb;
    bus.VBLK    = vb;
    bus.VID_AD  = vad;
    bus.PCLK_EN = 1'b1;
    tick();
    bus.PCLK_EN = 1'b0;
    chk({tg, ".e0_ad"}, 32'(bus.RAM_AD), 32'(ead));
    chk({tg, ".e0_we"}, 32'(bus.RAM_WE), 32'(ew));
    tick();
    chk({tg, ".e1_we"}, 32'(bus.RAM_WE), 32'(0));
    chk({tg, ".e1_dv_ack"},
        32'({bus.VID_DV, bus.CPU_ACK}), 32'(0));
    tick();
    chk({tg, ".e2_dv"}, 32'(bus.VID_DV), 32'(ev));
    chk({tg, ".e2_ack"}, 32'(bus.CPU_ACK), 32'(ec));
    if (ev)
      chk({tg, ".e2_vdt"}, 32'(bus.VID_DT), 32'(edt));
    if (ec && !ew)
      chk({tg, ".e2_cdt"}, 32'(bus.CPU_DT), 32'(edt));
    tick();
    chk({tg, ".e3_dv_ack"},
        32'({bus.VID_DV, bus.CPU_ACK}), 32'(0));
    last_ad = ead;
  endtask

  initial begin
    RESET       = 1'b1;
    bus.PCLK_EN = 1'b0;
    bus.HPOS    = '0;
    bus.HBLK    = 1'b0;
    bus.VBLK    = 1'b0;
    bus.VID_AD  = '0;
    bus.CPU_RQ  = 1'b0;
    bus.CPU_WE  = 1'b0;
    bus.CPU_AD  = '0;
    bus.CPU_DI  = '0;
    for (int i = 0; i < 16384; i++) ref_mem[i] = finit(i);

    bk_init = 1'b1;
    tick();
    bk_init = 1'b0;
    tick();
    chk("reset.ad", 32'(bus.RAM_AD), 32'(0));
    chk("reset.we", 32'(bus.RAM_WE), 32'(0));
    chk("reset.vid",
        32'({bus.VID_DV, bus.VID_DT}), 32'(0));
    chk("reset.cpu",
        32'({bus.CPU_ACK, bus.CPU_WAIT, bus.CPU_DT}),
        32'(0));
    RESET = 1'b0;
    tick();

    poke(14'h0123, 8'h5A);
    poke(14'h0200, 8'h77);

`ifdef VRAM_CPU_WBUF_EN
    bus.CPU_RQ = 1'b1;
    bus.CPU_WE = 1'b1;
    bus.CPU_AD = 14'h0040;
    bus.CPU_DI = 8'h11;
    tick();
    chk("wb.post_ack", 32'(bus.CPU_ACK), 32'(1));
    chk("wb.post_nowe", 32'(bus.RAM_WE), 32'(0));
    bus.CPU_RQ = 1'b0;
    tick();
    chk("wb.ack_drop", 32'(bus.CPU_ACK), 32'(0));
    bus.CPU_RQ = 1'b1;
    bus.CPU_WE = 1'b0;
    #1;
    chk("wb.rd_wait", 32'(bus.CPU_WAIT), 32'(1));
    slot("wb.vid_old", 9'd10, 1'b0, 1'b0, 14'h0040,
         1'b1, 1'b0, 1'b0, 14'h0040, ref_mem[14'h0040]);
    slot("wb.drain", 9'd11, 1'b0, 1'b0, 14'h0000,
         1'b0, 1'b0, 1'b1, 14'h0040, 8'h00);
    ref_mem[14'h0040] = 8'h11;
    slot("wb.vid_new", 9'd12, 1'b0, 1'b0, 14'h0040,
         1'b1, 1'b0, 1'b0, 14'h0040, 8'h11);
    slot("wb.read", 9'd13, 1'b0, 1'b0, 14'h0000,
         1'b0, 1'b1, 1'b0, 14'h0040, 8'h11);
    release_rq();
`else
    tbl[0]  = '{9'd10,  1'b0, 1'b0, 14'h0123, 1'b0, 1'b0,
                14'h0000, 8'h00, K_VID,  8'h5A};
    tbl[1]  = '{9'd11,  1'b0, 1'b0, 14'h0000, 1'b1, 1'b0,
                14'h0200, 8'h00, K_CPU,  8'h77};
    tbl[2]  = '{9'd10,  1'b0, 1'b1, 14'h0000, 1'b1, 1'b1,
                14'h0010, 8'h3C, K_CPU,  8'h00};
    tbl[3]  = '{9'd11,  1'b0, 1'b1, 14'h0000, 1'b1, 1'b0,
                14'h0010, 8'h00, K_CPU,  8'h3C};
    tbl[4]  = '{9'd20,  1'b1, 1'b0, 14'h0123, 1'b0, 1'b0,
                14'h0000, 8'h00, K_NONE, 8'h00};
    tbl[5]  = '{9'd12,  1'b0, 1'b0, 14'h0010, 1'b0, 1'b0,
                14'h0000, 8'h00, K_VID,  8'h3C};
    tbl[6]  = '{9'd13,  1'b0, 1'b0, 14'h0000, 1'b1, 1'b1,
                14'h3FFF, 8'hC7, K_CPU,  8'h00};
    tbl[7]  = '{9'd0,   1'b0, 1'b0, 14'h3FFF, 1'b0, 1'b0,
                14'h0000, 8'h00, K_VID,  8'hC7};
    tbl[8]  = '{9'h1FF, 1'b0, 1'b0, 14'h0123, 1'b1, 1'b0,
                14'h0000, 8'h00, K_CPU,  8'hA5};
    tbl[9]  = '{9'h1FE, 1'b1, 1'b1, 14'h0123, 1'b0, 1'b0,
                14'h0000, 8'h00, K_NONE, 8'h00};
    tbl[10] = '{9'd2,   1'b0, 1'b1, 14'h0000, 1'b1, 1'b0,
                14'h3FFF, 8'h00, K_CPU,  8'hC7};
    tbl[11] = '{9'd4,   1'b0, 1'b0, 14'h0200, 1'b0, 1'b0,
                14'h0000, 8'h00, K_VID,  8'h77};

    foreach (tbl[i]) begin
      v = tbl[i];
      bus.CPU_RQ = v.rq;
      bus.CPU_WE = v.we;
      bus.CPU_AD = v.cad;
      bus.CPU_DI = v.di;
      r_ead = (v.kind == K_VID) ? v.vad :
              (v.kind == K_CPU) ? v.cad : last_ad;
      slot($sformatf("vec%0d", i), v.hpos, v.hb, v.vb,
           v.vad, v.kind == K_VID, v.kind == K_CPU,
           v.kind == K_CPU && v.we, r_ead, v.dt);
      if (v.kind == K_CPU && v.we) ref_mem[v.cad] = v.di;
      release_rq();
    end

    bus.CPU_RQ = 1'b1;
    bus.CPU_WE = 1'b0;
    bus.CPU_AD = 14'h0200;
    slot("arr.vid", 9'd10, 1'b0, 1'b0, 14'h0123,
         1'b1, 1'b0, 1'b0, 14'h0123, 8'h5A);
    chk("arr.wait", 32'(bus.CPU_WAIT), 32'(1));
    slot("arr.cpu", 9'd11, 1'b0, 1'b0, 14'h0123,
         1'b0, 1'b1, 1'b0, 14'h0200, 8'h77);
    chk("arr.wait_done", 32'(bus.CPU_WAIT), 32'(0));
    release_rq();

    bus.CPU_RQ = 1'b1;
    bus.CPU_WE = 1'b1;
    bus.CPU_AD = 14'h0030;
    bus.CPU_DI = 8'h55;
    bus.VBLK   = 1'b1;
    nwe  = 0;
    nack = 0;
    for (int s = 0; s < 4; s++) begin
      bus.HPOS    = 9'(s);
      bus.PCLK_EN = 1'b1;
      for (int c = 0; c < 4; c++) begin
        tick();
        bus.PCLK_EN = 1'b0;
        nwe  += int'(bus.RAM_WE);
        nack += int'(bus.CPU_ACK);
      end
    end
    chk("held.we_count", 32'(nwe), 32'(1));
    chk("held.ack_count", 32'(nack), 32'(1));
    chk("held.wait", 32'(bus.CPU_WAIT), 32'(0));
    ref_mem[14'h0030] = 8'h55;
    last_ad = 14'h0030;
    release_rq();
    bus.CPU_RQ = 1'b1;
    bus.CPU_WE = 1'b0;
    slot("held.rd", 9'd3, 1'b0, 1'b1, 14'h0000,
         1'b0, 1'b1, 1'b0, 14'h0030, 8'h55);
    release_rq();

    bus.CPU_RQ  = 1'b1;
    bus.CPU_WE  = 1'b1;
    bus.CPU_AD  = 14'h0050;
    bus.CPU_DI  = 8'hEE;
    bus.HPOS    = 9'd1;
    bus.VBLK    = 1'b1;
    bus.PCLK_EN = 1'b1;
    tick();
    bus.PCLK_EN = 1'b0;
    chk("rst.we_pre", 32'(bus.RAM_WE), 32'(1));
    RESET = 1'b1;
    #1;
    chk("rst.we", 32'(bus.RAM_WE), 32'(0));
    chk("rst.ad", 32'(bus.RAM_AD), 32'(0));
    chk("rst.di", 32'(bus.RAM_DI), 32'(0));
    chk("rst.vid",
        32'({bus.VID_DV, bus.VID_DT}), 32'(0));
    chk("rst.cpu",
        32'({bus.CPU_ACK, bus.CPU_WAIT, bus.CPU_DT}),
        32'(0));
    nack = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      nack += int'(bus.CPU_ACK);
    end
    RESET = 1'b0;
    bus.CPU_RQ = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      nack += int'(bus.CPU_ACK);
    end
    chk("rst.no_ack", 32'(nack), 32'(0));
    last_ad = '0;
    bus.CPU_RQ = 1'b1;
    bus.CPU_WE = 1'b0;
    slot("rst.readback", 9'd5, 1'b0, 1'b1, 14'h0000,
         1'b0, 1'b1, 1'b0, 14'h0050, ref_mem[14'h0050]);
    release_rq();

    for (int i = 0; i < 150; i++) begin
      r_hp  = 9'($urandom_range(0, 511));
      r_hb  = ($urandom_range(0, 3) == 0);
      r_vb  = ($urandom_range(0, 3) == 0);
      r_vad = 14'($urandom_range(0, 31));
      if (!bus.CPU_RQ && $urandom_range(0, 1) == 1) begin
        bus.CPU_RQ = 1'b1;
        bus.CPU_WE = 1'($urandom_range(0, 1));
        bus.CPU_AD = 14'($urandom_range(0, 31));
        bus.CPU_DI = 8'($urandom_range(0, 255));
      end
      r_dt = 8'h00;
      if (!r_hb && !r_vb && !r_hp[0]) begin
        r_kind = K_VID;
        r_ead  = r_vad;
        r_dt   = ref_mem[r_vad];
      end else if (bus.CPU_RQ && !m_done) begin
        r_kind = K_CPU;
        r_ead  = bus.CPU_AD;
        r_dt   = ref_mem[bus.CPU_AD];
        if (bus.CPU_WE) ref_mem[bus.CPU_AD] = bus.CPU_DI;
        m_done = 1'b1;
      end else begin
        r_kind = K_NONE;
        r_ead  = last_ad;
      end
      slot($sformatf("rnd%0d", i), r_hp, r_hb, r_vb, r_vad,
           r_kind == K_VID, r_kind == K_CPU,
           r_kind == K_CPU && bus.CPU_WE, r_ead, r_dt);
      if (m_done && $urandom_range(0, 2) != 0) release_rq();
    end
    release_rq();
`endif

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
